// File: rtl/seven_seg_pkg.sv
// Shared constants, state encoding and helpers for the multiplexed 7-segment display driver.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Segment order {a,b,c,d,e,f,g}, active low.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic int clog2(input int n);
    int v;
    int r;
    v = n - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // A single digit still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n < 32'sd2) ? 32'sd1 : clog2(n);
  endfunction

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Codes above 9 cannot come out of the converter; they fall back to "0".
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DIGIT[0];
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, sticky overflow when a
// set bit leaves the top BCD nibble, done asserted for the single commit cycle.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int VALUE_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = clog2(VALUE_W + 32'sd1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_W - 32'sd1);

  conv_state_t        state;
  conv_state_t        state_nx;
  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_sh_nx;
  logic [BCD_W-1:0]   bcd_adj;
  logic [VALUE_W-1:0] val_sh;
  logic [VALUE_W-1:0] val_sh_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nx;
  logic               ovf_int;
  logic               ovf_int_nx;
  logic               busy_nx;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_sh  <= '0;
      val_sh  <= '0;
      bit_cnt <= '0;
      ovf_int <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      bcd_sh  <= bcd_sh_nx;
      val_sh  <= val_sh_nx;
      bit_cnt <= bit_cnt_nx;
      ovf_int <= ovf_int_nx;
      busy    <= busy_nx;
    end
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dd_adjust(bcd_sh[4*i +: 4]);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nx   = state;
    bcd_sh_nx  = bcd_sh;
    val_sh_nx  = val_sh;
    bit_cnt_nx = bit_cnt;
    ovf_int_nx = ovf_int;
    busy_nx    = busy;
    case (state)
      IDLE: begin
        if (load) begin
          val_sh_nx  = value;
          bcd_sh_nx  = '0;
          bit_cnt_nx = '0;
          ovf_int_nx = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end else begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        bcd_sh_nx  = {bcd_adj[BCD_W-2:0], val_sh[VALUE_W-1]};
        ovf_int_nx = ovf_int | bcd_adj[BCD_W-1];
        val_sh_nx  = val_sh << 1'b1;
        bit_cnt_nx = bit_cnt + CNT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          state_nx = DONE;
        end else begin
          state_nx = SHIFT;
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  assign done = (state == DONE);
  assign bcd  = bcd_sh;
  assign ovf  = ovf_int;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: binary-to-BCD conversion, digit scan,
// leading-zero blanking and overflow dashes, with registered AN/led pins.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int VALUE_W    = 16,
  parameter int REFRESH_W  = 17,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            led
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 32'sd1);
  localparam bit BLANK_EN = (BLANK_LZ != 32'sd0);

  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_ovf;
  logic [BCD_W-1:0]      disp_bcd;
  logic [REFRESH_W-1:0]  refresh_cnt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_nib;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] an_nx;
  logic [6:0]            led_nx;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Display value and overflow flag change together, only on a finished conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd <= '0;
      ovf      <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
      ovf      <= conv_ovf;
    end else begin
      disp_bcd <= disp_bcd;
      ovf      <= ovf;
    end
  end

  // Free-running dwell counter; the digit index steps on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_W'(1);
      if (&refresh_cnt) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end else begin
        idx <= idx;
      end
    end
  end

  // lz_mask[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (disp_bcd[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  // Select the scanned digit and build the next pin values.
  always_comb begin
    cur_nib = 4'd0;
    cur_lz  = 1'b0;
    an_nx   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx) == i) begin
        cur_nib  = disp_bcd[4*i +: 4];
        cur_lz   = lz_mask[i];
        an_nx[i] = 1'b0;
      end else begin
        an_nx[i] = 1'b1;
      end
    end
    if (ovf) begin
      led_nx = SEG_DASH;
    end else if (BLANK_EN && (idx != IDX_W'(0)) && cur_lz) begin
      led_nx = SEG_BLANK;
    end else begin
      led_nx = seg_encode(cur_nib);
    end
  end

  // Pin registers keep AN and led aligned so digit changes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN  <= '1;
      led <= SEG_BLANK;
    end else begin
      AN  <= an_nx;
      led <= led_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench: three driver instances (blanking on, blanking off, 4 digits).
module tb_seven_seg_scan_driver;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic        clk;
  logic        rst;
  logic [15:0] value_a, value_b, value_c;
  logic        load_a, load_b, load_c;
  logic        busy_a, busy_b, busy_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [7:0]  an_a, an_b;
  logic [3:0]  an_c;
  logic [6:0]  led_a, led_b, led_c;

  int total;
  int bad;
  logic [6:0] got_seg [8];

  seven_seg_scan_driver #(.NUM_DIGITS(8), .VALUE_W(16), .REFRESH_W(2), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .value(value_a), .load(load_a),
    .busy(busy_a), .ovf(ovf_a), .AN(an_a), .led(led_a));

  seven_seg_scan_driver #(.NUM_DIGITS(8), .VALUE_W(16), .REFRESH_W(2), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .value(value_b), .load(load_b),
    .busy(busy_b), .ovf(ovf_b), .AN(an_b), .led(led_b));

  seven_seg_scan_driver #(.NUM_DIGITS(4), .VALUE_W(16), .REFRESH_W(2), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst(rst), .value(value_c), .load(load_c),
    .busy(busy_c), .ovf(ovf_c), .AN(an_c), .led(led_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [7:0] an_of(input int sel);
    case (sel)
      0:       return an_a;
      1:       return an_b;
      default: return {4'hF, an_c};
    endcase
  endfunction

  function automatic logic [6:0] led_of(input int sel);
    case (sel)
      0:       return led_a;
      1:       return led_b;
      default: return led_c;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [15:0] v, input logic l);
    case (sel)
      0:       begin value_a = v; load_a = l; end
      1:       begin value_b = v; load_b = l; end
      default: begin value_c = v; load_c = l; end
    endcase
  endtask

  // Pulse load, optionally re-pulse it at cycle extra_at, and count cycles busy stays high.
  task automatic do_load(input int sel, input logic [15:0] v, input int extra_at,
                         input logic [15:0] extra_v, output int n);
    drive(sel, v, 1'b1);
    @(negedge clk);
    n = 0;
    while (busy_of(sel) && n < 40) begin
      n++;
      if (n == extra_at) drive(sel, extra_v, 1'b1);
      else drive(sel, v, 1'b0);
      @(negedge clk);
    end
    drive(sel, v, 1'b0);
  endtask

  // Watch one full scan frame and compare each digit's segments; exp holds digit i at [7*i +: 7].
  task automatic check_frame(input int sel, input int nd, input logic [55:0] exp, input string tag);
    logic [7:0] seen;
    logic [7:0] an_cur;
    logic [7:0] an_exp;
    logic [7:0] want_seen;
    seen = 8'h00;
    for (int i = 0; i < 8; i++) got_seg[i] = 7'bxxxxxxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      an_cur = an_of(sel);
      for (int i = 0; i < nd; i++) begin
        an_exp = ~(8'd1 << i);
        if (an_cur == an_exp) begin
          got_seg[i] = led_of(sel);
          seen[i] = 1'b1;
        end
      end
    end
    want_seen = (nd == 8) ? 8'hFF : 8'h0F;
    chk($sformatf("%s_scan", tag), {24'd0, seen}, {24'd0, want_seen});
    for (int i = 0; i < nd; i++) begin
      chk($sformatf("%s_d%0d", tag, i), {25'd0, got_seg[i]}, {25'd0, exp[7*i +: 7]});
    end
  endtask

  initial begin
    int n;
    logic [7:0] an_exp;
    total = 0;
    bad = 0;
    rst = 1'b1;
    value_a = 16'd0; value_b = 16'd0; value_c = 16'd0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'd0, an_a}, 32'hFF);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
    rst = 1'b0;

    // Idle scan after reset: 4-cycle dwell per digit, single "0" on digit 0.
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      an_exp = ~(8'd1 << (k / 4));
      chk($sformatf("idle_an_%0d", k), {24'd0, an_a}, {24'd0, an_exp});
      chk($sformatf("idle_led_%0d", k), {25'd0, led_a}, {25'd0, ((k / 4) == 0) ? S0 : SB});
    end

    do_load(0, 16'd1234, 0, 16'd0, n);
    chk("bcd1234_busy", n, 32'd17);
    chk("bcd1234_ovf", {31'd0, ovf_a}, 32'd0);
    check_frame(0, 8, {SB, SB, SB, SB, S1, S2, S3, S4}, "bcd1234");

    do_load(0, 16'd1234, 5, 16'd999, n);
    chk("ign999_busy", n, 32'd17);
    repeat (3) @(negedge clk);
    chk("ign999_noqueue", {31'd0, busy_a}, 32'd0);
    check_frame(0, 8, {SB, SB, SB, SB, S1, S2, S3, S4}, "ign999");

    do_load(1, 16'd65535, 0, 16'd0, n);
    chk("nolz_busy", n, 32'd17);
    chk("nolz_ovf", {31'd0, ovf_b}, 32'd0);
    check_frame(1, 8, {S0, S0, S0, S6, S5, S5, S3, S5}, "nolz");

    do_load(2, 16'd12345, 0, 16'd0, n);
    chk("ovf_busy", n, 32'd17);
    chk("ovf_set", {31'd0, ovf_c}, 32'd1);
    check_frame(2, 4, {28'd0, SD, SD, SD, SD}, "ovf");
    do_load(2, 16'd42, 0, 16'd0, n);
    chk("ovf_clr", {31'd0, ovf_c}, 32'd0);
    check_frame(2, 4, {28'd0, SB, SB, S4, S2}, "d42");

    // Reset in the middle of a conversion, then a clean conversion.
    drive(0, 16'd4321, 1'b1);
    @(negedge clk);
    drive(0, 16'd4321, 1'b0);
    repeat (7) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_ovf", {31'd0, ovf_a}, 32'd0);
    check_frame(0, 8, {SB, SB, SB, SB, SB, SB, SB, S0}, "abort");
    do_load(0, 16'd4321, 0, 16'd0, n);
    chk("after_abort_busy", n, 32'd17);
    check_frame(0, 8, {SB, SB, SB, SB, S4, S3, S2, S1}, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
